// File: rtl/md_hazard_unit_pkg.sv
// Shared constants for the E-stage multiply/divide and hazard unit:
// op encodings, default latencies and datapath widths.
package md_hazard_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned DLEN = 64;

    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    // Ops that occupy the unit for a multi-cycle computation.
    function automatic logic md_is_arith(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_mult(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_hazard_unit_if.sv
// E-stage MD request and pipeline-control bundle between the pipeline and
// the multiply/divide hazard unit.
interface md_hazard_unit_if;
    import md_hazard_unit_pkg::*;

    logic [3:0]      E_md_op;
    logic [XLEN-1:0] E_rs_val;
    logic [XLEN-1:0] E_rt_val;
    logic            D_ext_stall;
    logic [XLEN-1:0] md_rdata;
    logic            md_busy;
    logic            PC_en;
    logic            FD_en;
    logic            DE_en;
    logic            DE_clear;
    logic            EM_en;
    logic            EM_clear;
    logic [XLEN-1:0] HI;
    logic [XLEN-1:0] LO;

    modport master (
        output E_md_op, E_rs_val, E_rt_val, D_ext_stall,
        input  md_rdata, md_busy, PC_en, FD_en, DE_en, DE_clear, EM_en, EM_clear, HI, LO
    );

    modport slave (
        input  E_md_op, E_rs_val, E_rt_val, D_ext_stall,
        output md_rdata, md_busy, PC_en, FD_en, DE_en, DE_clear, EM_en, EM_clear, HI, LO
    );

endinterface

// File: rtl/md_datapath.sv
// Combinational signed/unsigned multiply and divide producing {hi, lo, valid};
// valid is low only for a divide by zero.
module md_datapath
    import md_hazard_unit_pkg::*;
(
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] rs,
    input  logic [XLEN-1:0] rt,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            valid
);

    logic            is_signed;
    logic [DLEN-1:0] prod;
    logic [XLEN-1:0] ua, ub, dvsr, uq, ur;

    always_comb begin
        is_signed = (op == MD_MULT) || (op == MD_DIV);
        prod = is_signed ? ({{XLEN{rs[XLEN-1]}}, rs} * {{XLEN{rt[XLEN-1]}}, rt})
                         : ({{XLEN{1'b0}}, rs} * {{XLEN{1'b0}}, rt});
        // Divide on magnitudes, then restore signs: quotient truncates toward
        // zero and the remainder follows the dividend.
        ua   = (is_signed && rs[XLEN-1]) ? -rs : rs;
        ub   = (is_signed && rt[XLEN-1]) ? -rt : rt;
        dvsr = (ub == '0) ? XLEN'(1) : ub;
        uq   = ua / dvsr;
        ur   = ua % dvsr;

        hi    = '0;
        lo    = '0;
        valid = 1'b0;
        case (op)
            MD_MULT, MD_MULTU: begin
                hi    = prod[DLEN-1:XLEN];
                lo    = prod[XLEN-1:0];
                valid = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
                lo    = (is_signed && (rs[XLEN-1] ^ rt[XLEN-1])) ? -uq : uq;
                hi    = (is_signed && rs[XLEN-1]) ? -ur : ur;
                valid = (rt != '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_hazard_unit.sv
// E-stage multiply/divide unit owning HI/LO, plus the stall/flush controller
// for the F/D, D/E and E/M pipeline registers.
module md_hazard_unit
    import md_hazard_unit_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    md_hazard_unit_if.slave md
);

    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [XLEN-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic            pend_valid_q, pend_valid_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d;

    logic [XLEN-1:0] dp_hi, dp_lo;
    logic            dp_valid;
    logic            e_md_any, md_stall, start;

    md_datapath u_datapath (
        .op    (md.E_md_op),
        .rs    (md.E_rs_val),
        .rt    (md.E_rt_val),
        .hi    (dp_hi),
        .lo    (dp_lo),
        .valid (dp_valid)
    );

    assign e_md_any = (md.E_md_op >= MD_MULT) && (md.E_md_op <= MD_MTLO);
    assign md_stall = e_md_any & busy_q;
    assign start    = md_is_arith(md.E_md_op) & ~busy_q;

    // md_stall has priority: E is held in place, so D/E must hold, not clear.
    assign md.PC_en    = ~(md_stall | md.D_ext_stall);
    assign md.FD_en    = ~(md_stall | md.D_ext_stall);
    assign md.DE_en    = ~md_stall;
    assign md.DE_clear = md.D_ext_stall & ~md_stall;
    assign md.EM_en    = 1'b1;
    assign md.EM_clear = md_stall;

    assign md.md_busy  = busy_q;
    assign md.HI       = hi_q;
    assign md.LO       = lo_q;
    assign md.md_rdata = (md.E_md_op == MD_MFHI) ? hi_q :
                         (md.E_md_op == MD_MFLO) ? lo_q : '0;

    always_comb begin
        hi_d         = hi_q;
        lo_d         = lo_q;
        pend_hi_d    = pend_hi_q;
        pend_lo_d    = pend_lo_q;
        pend_valid_d = pend_valid_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;

        if (start) begin
            pend_hi_d    = dp_hi;
            pend_lo_d    = dp_lo;
            pend_valid_d = dp_valid;
            cnt_d        = md_is_mult(md.E_md_op) ? 4'(MULT_LAT) : 4'(DIV_LAT);
            busy_d       = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == 4'd1) begin
                if (pend_valid_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
                cnt_d  = '0;
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (md.E_md_op == MD_MTHI) begin
            hi_d = md.E_rs_val;
        end else if (md.E_md_op == MD_MTLO) begin
            lo_d = md.E_rs_val;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q         <= '0;
            lo_q         <= '0;
            pend_hi_q    <= '0;
            pend_lo_q    <= '0;
            pend_valid_q <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
        end else begin
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            pend_hi_q    <= pend_hi_d;
            pend_lo_q    <= pend_lo_d;
            pend_valid_q <= pend_valid_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: tb/tb_md_hazard_unit.sv
// Scoreboard bench for md_hazard_unit: expected HI/LO/rdata are queued when an
// op is issued and compared when the unit delivers them.
module tb_md_hazard_unit;
    import md_hazard_unit_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    md_hazard_unit_if bus ();

    md_hazard_unit #(
        .MULT_LAT (5),
        .DIV_LAT  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // {PC_en, FD_en, DE_en, DE_clear, EM_en, EM_clear, md_busy}
    localparam logic [6:0] CtrlIdle    = 7'b1110100;
    localparam logic [6:0] CtrlMdStall = 7'b0000111;
    localparam logic [6:0] CtrlExtOnly = 7'b0011100;

    function automatic logic [6:0] ctrl();
        return {bus.PC_en, bus.FD_en, bus.DE_en, bus.DE_clear, bus.EM_en, bus.EM_clear,
                bus.md_busy};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] got);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, got, e.val);
        end
    endtask

    // One E-stage instruction per cycle; outputs sampled 2 time units after the edge.
    task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic ext);
        @(posedge clk);
        #1;
        bus.E_md_op     = op;
        bus.E_rs_val    = rs;
        bus.E_rt_val    = rt;
        bus.D_ext_stall = ext;
        #1;
    endtask

    task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int lat);
        int busy_n;
        int em_bad;
        busy_n = 0;
        em_bad = 0;
        drive(op, rs, rt, 1'b0);
        check({tag, "_start_ctrl"}, 32'(ctrl()), 32'(CtrlIdle));
        sb_push({tag, "_hi"}, exp_hi);
        sb_push({tag, "_lo"}, exp_lo);
        for (int i = 0; i < 40; i++) begin
            drive(MD_NONE, 32'd0, 32'd0, 1'b0);
            if (!bus.md_busy) break;
            busy_n++;
            if (bus.EM_clear) em_bad++;
        end
        check({tag, "_busy_cycles"}, busy_n, lat);
        check({tag, "_em_clear"}, em_bad, 0);
        sb_check(bus.HI);
        sb_check(bus.LO);
    endtask

    initial begin
        int held;
        int bad;
        bus.E_md_op     = MD_NONE;
        bus.E_rs_val    = '0;
        bus.E_rt_val    = '0;
        bus.D_ext_stall = 1'b0;

        #12;
        check("reset_hi", bus.HI, 32'd0);
        check("reset_lo", bus.LO, 32'd0);
        check("reset_ctrl", 32'(ctrl()), 32'(CtrlIdle));
        @(negedge clk);
        reset = 1'b1;

        run_md("mult", MD_MULT, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);

        // DIVU followed at once by MFLO: MFLO held in E for the whole divide.
        held = 0;
        bad  = 0;
        drive(MD_DIVU, 32'd17, 32'd5, 1'b0);
        sb_push("divu_mflo", 32'd3);
        sb_push("divu_mfhi", 32'd2);
        for (int i = 0; i < 40; i++) begin
            drive(MD_MFLO, 32'd0, 32'd0, 1'b0);
            if (!bus.md_busy) break;
            held++;
            if (ctrl() !== CtrlMdStall) bad++;
        end
        check("divu_held_cycles", held, 10);
        check("divu_stall_ctrl", bad, 0);
        check("divu_release_ctrl", 32'(ctrl()), 32'(CtrlIdle));
        sb_check(bus.md_rdata);
        drive(MD_MFHI, 32'd0, 32'd0, 1'b0);
        sb_check(bus.md_rdata);

        run_md("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        run_md("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);

        // MTHI/MTLO are not blocked by the D-stage stall.
        drive(MD_MTHI, 32'h11, 32'd0, 1'b1);
        drive(MD_MTLO, 32'h22, 32'd0, 1'b0);
        drive(MD_MFHI, 32'd0, 32'd0, 1'b1);
        check("mthi_rdata", bus.md_rdata, 32'h11);
        check("ext_only_ctrl", 32'(ctrl()), 32'(CtrlExtOnly));
        drive(MD_MFLO, 32'd0, 32'd0, 1'b0);
        check("mtlo_rdata", bus.md_rdata, 32'h22);
        run_md("div_zero", MD_DIV, 32'd100, 32'd0, 32'h11, 32'h22, 10);

        // Reset in the third busy cycle of a MULT.
        drive(MD_MULT, 32'd3, 32'd7, 1'b0);
        drive(MD_NONE, 32'd0, 32'd0, 1'b0);
        drive(MD_NONE, 32'd0, 32'd0, 1'b0);
        drive(MD_NONE, 32'd0, 32'd0, 1'b0);
        check("rst_mid_busy_before", 32'(bus.md_busy), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_busy", 32'(bus.md_busy), 32'd0);
        check("rst_mid_hi", bus.HI, 32'd0);
        check("rst_mid_lo", bus.LO, 32'd0);
        #3;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) drive(MD_NONE, 32'd0, 32'd0, 1'b0);
        check("rst_no_commit_hi", bus.HI, 32'd0);
        check("rst_no_commit_lo", bus.LO, 32'd0);
        check("rst_no_commit_busy", 32'(bus.md_busy), 32'd0);

        // MFHI with D_ext_stall while busy: md_stall wins.
        drive(MD_MULT, 32'h0001_0000, 32'h0001_0000, 1'b0);
        sb_push("ext_mfhi_rdata", 32'd1);
        drive(MD_MFHI, 32'd0, 32'd0, 1'b1);
        check("both_stall_ctrl", 32'(ctrl()), 32'(CtrlMdStall));
        for (int i = 0; i < 40; i++) begin
            if (!bus.md_busy) break;
            drive(MD_MFHI, 32'd0, 32'd0, 1'b1);
        end
        check("ext_after_busy_ctrl", 32'(ctrl()), 32'(CtrlExtOnly));
        sb_check(bus.md_rdata);

        // MD op starts normally under D_ext_stall when the unit is idle.
        drive(MD_MULT, 32'd2, 32'd3, 1'b1);
        check("start_under_ext_ctrl", 32'(ctrl()), 32'(CtrlExtOnly));
        sb_push("ext_start_lo", 32'd6);
        drive(MD_NONE, 32'd0, 32'd0, 1'b0);
        check("start_under_ext_busy", 32'(bus.md_busy), 32'd1);
        for (int i = 0; i < 40; i++) begin
            if (!bus.md_busy) break;
            drive(MD_NONE, 32'd0, 32'd0, 1'b0);
        end
        sb_check(bus.LO);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
